// File: rtl/csr_trap_if.sv
// CSR access, trap and interrupt signals between the core commit path and the CSR unit.
interface csr_trap_if #(parameter int XLEN = 32);
    logic            csr_v_i;
    logic [1:0]      csr_op_i;
    logic [11:0]     csr_adr_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic            csr_illegal_o;
    logic            instret_i;
    logic            exception_v_i;
    logic [XLEN-1:0] exception_cause_i;
    logic [XLEN-1:0] exception_pc_i;
    logic [XLEN-1:0] exception_tval_i;
    logic            mret_i;
    logic            irq_ext_i;
    logic            irq_timer_i;
    logic            irq_sw_i;
    logic            irq_pending_o;
    logic [XLEN-1:0] trap_target_o;
    logic [XLEN-1:0] mepc_q_o;

    // Core side: issues CSR ops, retire/trap/mret events and raw interrupt lines.
    modport master (
        output csr_v_i, csr_op_i, csr_adr_i, csr_wdata_i, instret_i,
               exception_v_i, exception_cause_i, exception_pc_i, exception_tval_i,
               mret_i, irq_ext_i, irq_timer_i, irq_sw_i,
        input  csr_rdata_o, csr_illegal_o, irq_pending_o, trap_target_o, mepc_q_o
    );

    // CSR unit side.
    modport slave (
        input  csr_v_i, csr_op_i, csr_adr_i, csr_wdata_i, instret_i,
               exception_v_i, exception_cause_i, exception_pc_i, exception_tval_i,
               mret_i, irq_ext_i, irq_timer_i, irq_sw_i,
        output csr_rdata_o, csr_illegal_o, irq_pending_o, trap_target_o, mepc_q_o
    );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR unit: atomic RW/RS/RC, trap entry/exit, interrupt pending,
// vectored mtvec and 64-bit mcycle/minstret with inhibit.
module csr_trap_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] HARTID      = '0,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input logic       clk,
    input logic       reset_n,
    csr_trap_if.slave bus
);
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    logic            mie_q, mpie_q;
    logic [2:0]      mie_en_q;      // {MEIE, MTIE, MSIE}
    logic [2:0]      mip_q;         // {MEIP, MTIP, MSIP}
    logic [XLEN-1:2] mtvec_base_q;
    logic [1:0]      mtvec_mode_q;
    logic [XLEN-1:0] mscratch_q, mepc_q, mcause_q, mtval_q;
    logic            inh_cy_q, inh_ir_q;
    logic [63:0]     mcycle_q, minstret_q;

    logic            access, wr_req, mapped, illegal, we;
    logic [XLEN-1:0] old_val, wval, mtvec_base;

    // Read mux: architectural view of every mapped CSR; unmapped flags mapped=0.
    always_comb begin
        old_val = '0;
        mapped  = 1'b1;
        case (bus.csr_adr_i)
            12'h300: begin
                old_val[12:11] = 2'b11;
                old_val[7]     = mpie_q;
                old_val[3]     = mie_q;
            end
            12'h301: old_val = XLEN'(32'h4000_0100);
            12'h304: begin
                old_val[11] = mie_en_q[2];
                old_val[7]  = mie_en_q[1];
                old_val[3]  = mie_en_q[0];
            end
            12'h305: old_val = {mtvec_base_q, mtvec_mode_q};
            12'h310, 12'hF11, 12'hF12, 12'hF13: old_val = '0;
            12'h320: begin
                old_val[2] = inh_ir_q;
                old_val[0] = inh_cy_q;
            end
            12'h340: old_val = mscratch_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'h343: old_val = mtval_q;
            12'h344: begin
                old_val[11] = mip_q[2];
                old_val[7]  = mip_q[1];
                old_val[3]  = mip_q[0];
            end
            12'hB00: old_val = mcycle_q[31:0];
            12'hB80: old_val = mcycle_q[63:32];
            12'hB02: old_val = minstret_q[31:0];
            12'hB82: old_val = minstret_q[63:32];
            12'hF14: old_val = HARTID;
            default: mapped = 1'b0;
        endcase
    end

    // Legality and write value; RS/RC with a zero operand is a pure read.
    // A trap or mret in the same cycle silently drops the CSR write.
    always_comb begin
        access  = bus.csr_v_i && (bus.csr_op_i != 2'b00);
        wr_req  = (bus.csr_op_i == OP_RW) || (bus.csr_wdata_i != '0);
        illegal = access && (!mapped || (wr_req && (bus.csr_adr_i[11:10] == 2'b11)));
        we      = access && wr_req && !illegal && !bus.exception_v_i && !bus.mret_i;
        case (bus.csr_op_i)
            OP_RS:   wval = old_val | bus.csr_wdata_i;
            OP_RC:   wval = old_val & ~bus.csr_wdata_i;
            default: wval = bus.csr_wdata_i;
        endcase
    end

    assign mtvec_base        = {mtvec_base_q, 2'b00};
    assign bus.csr_rdata_o   = (access && !illegal) ? old_val : '0;
    assign bus.csr_illegal_o = illegal;
    assign bus.irq_pending_o = mie_q && |(mip_q & mie_en_q);
    assign bus.mepc_q_o      = mepc_q;
    // Vectored mode only redirects interrupts; exceptions always go to base.
    assign bus.trap_target_o = (mtvec_mode_q == 2'b01 && bus.exception_cause_i[XLEN-1])
                             ? mtvec_base + {bus.exception_cause_i[XLEN-3:0], 2'b00}
                             : mtvec_base;

    // Interrupt lines sampled into mip with one cycle of latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mip_q <= '0;
        else          mip_q <= {bus.irq_ext_i, bus.irq_timer_i, bus.irq_sw_i};
    end

    // Counters: a CSR write to one half replaces that cycle's increment, the other half holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (we && bus.csr_adr_i == 12'hB00)      mcycle_q[31:0]  <= wval[31:0];
            else if (we && bus.csr_adr_i == 12'hB80) mcycle_q[63:32] <= wval[31:0];
            else if (!inh_cy_q)                      mcycle_q        <= mcycle_q + 64'd1;

            if (we && bus.csr_adr_i == 12'hB02)      minstret_q[31:0]  <= wval[31:0];
            else if (we && bus.csr_adr_i == 12'hB82) minstret_q[63:32] <= wval[31:0];
            else if (bus.instret_i && !inh_ir_q)     minstret_q        <= minstret_q + 64'd1;
        end
    end

    // Trap/mret/CSR-write state, in priority order trap > mret > write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mie_q        <= 1'b0;
            mpie_q       <= 1'b0;
            mie_en_q     <= '0;
            mtvec_base_q <= MTVEC_RESET[XLEN-1:2];
            mtvec_mode_q <= MTVEC_RESET[1:0];
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            inh_cy_q     <= 1'b0;
            inh_ir_q     <= 1'b0;
        end else if (bus.exception_v_i) begin
            mepc_q   <= {bus.exception_pc_i[XLEN-1:1], 1'b0};
            mcause_q <= bus.exception_cause_i;
            mtval_q  <= bus.exception_tval_i;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (bus.mret_i) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (we) begin
            case (bus.csr_adr_i)
                12'h300: begin
                    mie_q  <= wval[3];
                    mpie_q <= wval[7];
                end
                12'h304: mie_en_q <= {wval[11], wval[7], wval[3]};
                12'h305: begin
                    mtvec_base_q <= wval[XLEN-1:2];
                    if (!wval[1]) mtvec_mode_q <= wval[1:0];
                end
                12'h320: begin
                    inh_cy_q <= wval[0];
                    inh_ir_q <= wval[2];
                end
                12'h340: mscratch_q <= wval;
                12'h341: mepc_q     <= {wval[XLEN-1:1], 1'b0};
                12'h342: mcause_q   <= wval;
                12'h343: mtval_q    <= wval;
                default: ;
            endcase
        end
    end
endmodule
